// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and constants for the UART command framer.
//   cmd_state_t      : framer FSM states (3-bit encoding)
//   SYNC_BYTE_DEF    : default frame start marker
//   FRAME_LEN        : bytes per frame (SYNC, OP, A, B, CHK)
//   frame_checksum() : XOR of opcode and both operands
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_OP   = 3'd1,
        S_A    = 3'd2,
        S_B    = 3'd3,
        S_CHK  = 3'd4,
        S_HOLD = 3'd5
    } cmd_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
    localparam int         FRAME_LEN     = 5;

    function automatic logic [7:0] frame_checksum(input logic [7:0] op,
                                                  input logic [7:0] a,
                                                  input logic [7:0] b);
        return op ^ a ^ b;
    endfunction

endpackage

// File: rtl/uart_timeout_ctr.sv
// ---------------------------------------------------------------------------
// uart_timeout_ctr
// Inter-byte idle counter used by the framer while a frame is in flight.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   clr     : force the count back to zero (takes priority over en)
//   en      : count one idle cycle
//   expired : count has reached TIMEOUT_CLKS-1
// ---------------------------------------------------------------------------
module uart_timeout_ctr
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 43400,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] cnt;

    // The count represents idle cycles since the last accepted byte; a clear
    // always wins so a byte arriving on the expiry cycle restarts the window.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/uart_cmd_framer.sv
// ---------------------------------------------------------------------------
// uart_cmd_framer
// Assembles SYNC,OP,A,B,CHK byte frames from the UART receiver into an ALU
// command, validates the XOR checksum and offers the command on a
// valid/ready handshake. Garbage, bad frames and stalled frames are dropped.
//   clk, rst              : clock, synchronous active-high reset
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   cmd_op, cmd_a, cmd_b  : command fields, stable while cmd_valid=1
//   cmd_valid, cmd_ready  : command handshake
//   err_chk               : pulse, checksum mismatch
//   err_timeout           : pulse, inter-byte timeout inside a frame
//   err_overrun           : pulse, byte dropped while holding a command
//   busy                  : framer is not waiting for SYNC
// All outputs are registered.
// ---------------------------------------------------------------------------
module uart_cmd_framer
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 43400,
    parameter int         CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] cmd_op,
    output logic [7:0] cmd_a,
    output logic [7:0] cmd_b,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       err_chk,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy
);

    cmd_state_t state, state_next;

    logic [7:0] op_r, a_r, b_r;
    logic [7:0] op_next, a_next, b_next;
    logic [7:0] cmd_op_next, cmd_a_next, cmd_b_next;
    logic       err_chk_next, err_timeout_next, err_overrun_next;

    logic in_frame;
    logic tmo_clr, tmo_en, tmo_expired;

    // Only the payload/checksum states are subject to the inter-byte timeout;
    // the hold state may stall for as long as the consumer likes.
    assign in_frame = (state == S_OP) || (state == S_A) ||
                      (state == S_B)  || (state == S_CHK);
    assign tmo_clr  = !in_frame || rx_valid || tmo_expired;
    assign tmo_en   = in_frame && !rx_valid;

    uart_timeout_ctr #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS),
        .CNT_W        (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // State register plus every registered output. cmd_valid and busy are
    // derived from the next state so they line up exactly with the state
    // they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_SYNC;
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            cmd_op      <= '0;
            cmd_a       <= '0;
            cmd_b       <= '0;
            cmd_valid   <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            op_r        <= op_next;
            a_r         <= a_next;
            b_r         <= b_next;
            cmd_op      <= cmd_op_next;
            cmd_a       <= cmd_a_next;
            cmd_b       <= cmd_b_next;
            cmd_valid   <= (state_next == S_HOLD);
            err_chk     <= err_chk_next;
            err_timeout <= err_timeout_next;
            err_overrun <= err_overrun_next;
            busy        <= (state_next != S_SYNC);
        end
    end

    // Next-state and datapath decisions. A byte always beats an expiring
    // timeout, SYNC inside the payload is plain data, and any byte seen
    // while holding a command is dropped and flagged as an overrun.
    always_comb begin
        state_next       = state;
        op_next          = op_r;
        a_next           = a_r;
        b_next           = b_r;
        cmd_op_next      = cmd_op;
        cmd_a_next       = cmd_a;
        cmd_b_next       = cmd_b;
        err_chk_next     = 1'b0;
        err_timeout_next = 1'b0;
        err_overrun_next = 1'b0;

        case (state)
            S_SYNC: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_next = S_OP;
                end
            end
            S_OP: begin
                if (rx_valid) begin
                    op_next    = rx_data;
                    state_next = S_A;
                end else if (tmo_expired) begin
                    err_timeout_next = 1'b1;
                    state_next       = S_SYNC;
                end
            end
            S_A: begin
                if (rx_valid) begin
                    a_next     = rx_data;
                    state_next = S_B;
                end else if (tmo_expired) begin
                    err_timeout_next = 1'b1;
                    state_next       = S_SYNC;
                end
            end
            S_B: begin
                if (rx_valid) begin
                    b_next     = rx_data;
                    state_next = S_CHK;
                end else if (tmo_expired) begin
                    err_timeout_next = 1'b1;
                    state_next       = S_SYNC;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == frame_checksum(op_r, a_r, b_r)) begin
                        cmd_op_next = op_r;
                        cmd_a_next  = a_r;
                        cmd_b_next  = b_r;
                        state_next  = S_HOLD;
                    end else begin
                        err_chk_next = 1'b1;
                        state_next   = S_SYNC;
                    end
                end else if (tmo_expired) begin
                    err_timeout_next = 1'b1;
                    state_next       = S_SYNC;
                end
            end
            S_HOLD: begin
                if (rx_valid) begin
                    err_overrun_next = 1'b1;
                end
                if (cmd_valid && cmd_ready) begin
                    state_next = S_SYNC;
                end
            end
            default: begin
                state_next = S_SYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_framer
// Self-checking bench for uart_cmd_framer: directed frames with literal
// expectations, then randomized frames compared every cycle against a
// byte-queue reference model of the framing rules.
// ---------------------------------------------------------------------------
module tb_uart_cmd_framer;
    import uart_cmd_pkg::*;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_ready;
    logic [7:0] cmd_op, cmd_a, cmd_b;
    logic       cmd_valid, err_chk, err_timeout, err_overrun, busy;

    uart_cmd_framer #(
        .SYNC_BYTE    (8'hAA),
        .TIMEOUT_CLKS (T),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .err_chk     (err_chk),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: the frame is a queue of bytes collected after SYNC,
    // the idle gap is counted in cycles, and a held command waits for ready.
    bit         m_in_frame = 0;
    bit         m_hold     = 0;
    logic [7:0] m_q[$];
    int         m_gap      = 0;
    logic [7:0] m_op = 0, m_a = 0, m_b = 0;
    bit         e_chk = 0, e_to = 0, e_ov = 0;

    always @(posedge clk) begin
        e_chk = 0;
        e_to  = 0;
        e_ov  = 0;
        if (rst) begin
            m_in_frame = 0;
            m_hold     = 0;
            m_q.delete();
            m_gap = 0;
            m_op  = 0;
            m_a   = 0;
            m_b   = 0;
        end else if (m_hold) begin
            if (rx_valid) e_ov = 1;
            if (cmd_ready) m_hold = 0;
        end else if (m_in_frame) begin
            if (rx_valid) begin
                m_q.push_back(rx_data);
                m_gap = 0;
                if (m_q.size() == FRAME_LEN - 1) begin
                    if ((m_q[0] ^ m_q[1] ^ m_q[2]) == m_q[3]) begin
                        m_hold = 1;
                        m_op   = m_q[0];
                        m_a    = m_q[1];
                        m_b    = m_q[2];
                    end else begin
                        e_chk = 1;
                    end
                    m_in_frame = 0;
                    m_q.delete();
                end
            end else begin
                m_gap++;
                if (m_gap == T) begin
                    e_to       = 1;
                    m_in_frame = 0;
                    m_q.delete();
                end
            end
        end else if (rx_valid && rx_data == 8'hAA) begin
            m_in_frame = 1;
            m_gap      = 0;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_hold});
            checkOutput("busy", {31'd0, busy}, {31'd0, (m_in_frame || m_hold)});
            checkOutput("err_chk", {31'd0, err_chk}, {31'd0, e_chk});
            checkOutput("err_timeout", {31'd0, err_timeout}, {31'd0, e_to});
            checkOutput("err_overrun", {31'd0, err_overrun}, {31'd0, e_ov});
            if (m_hold) begin
                checkOutput("cmd_op", {24'd0, cmd_op}, {24'd0, m_op});
                checkOutput("cmd_a", {24'd0, cmd_a}, {24'd0, m_a});
                checkOutput("cmd_b", {24'd0, cmd_b}, {24'd0, m_b});
            end
        end
    end

    // Event observers used by the directed tests.
    int n_valid = 0, n_chk = 0, n_to = 0, n_ov = 0, n_hs = 0;
    int valid_start = 0, to_cyc = 0;
    logic [7:0] cap_op = 0, cap_a = 0, cap_b = 0;
    bit prev_valid = 0;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            n_valid++;
            cap_op = cmd_op;
            cap_a  = cmd_a;
            cap_b  = cmd_b;
            if (!prev_valid) valid_start = cyc;
        end
        prev_valid = (cmd_valid === 1'b1);
        if (err_chk === 1'b1) n_chk++;
        if (err_timeout === 1'b1) begin
            n_to++;
            to_cyc = cyc;
        end
        if (err_overrun === 1'b1) n_ov++;
    end

    always @(posedge clk) begin
        if (rst === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) n_hs++;
    end

    int b_valid, b_chk, b_to, b_ov, b_hs, e0;

    task automatic snap();
        #2;
        b_valid = n_valid;
        b_chk   = n_chk;
        b_to    = n_to;
        b_ov    = n_ov;
        b_hs    = n_hs;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        rx_valid  = v;
        rx_data   = d;
        cmd_ready = r;
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) applyStimulus(1'b0, 8'h00, r);
    endtask

    task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic r);
        applyStimulus(1'b1, b0, r);
        applyStimulus(1'b1, b1, r);
        applyStimulus(1'b1, b2, r);
        applyStimulus(1'b1, b3, r);
        applyStimulus(1'b1, b4, r);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst       = 1'b1;
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] rnd_byte();
        return ($urandom_range(0, 7) == 0) ? 8'hAA : 8'($urandom);
    endfunction

    function automatic logic rnd_ready();
        return ($urandom_range(0, 2) != 0);
    endfunction

    task automatic send_gap(input int g);
        repeat (g) applyStimulus(1'b0, 8'($urandom), rnd_ready());
    endtask

    logic [7:0] fb[5];
    int k, n;

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        @(negedge clk);
        cmd_en_block: cmp_en = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("reset.cmd_valid", {31'd0, cmd_valid}, 32'd0);
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);
        checkOutput("reset.errs", {29'd0, err_chk, err_timeout, err_overrun}, 32'd0);
        checkOutput("reset.cmd_fields", {8'd0, cmd_op, cmd_a, cmd_b}, 32'd0);

        // Good frame with immediate acceptance.
        snap();
        send5(8'hAA, 8'h03, 8'h12, 8'h34, 8'h25, 1'b1);
        e0 = cyc + 1;
        idle(4, 1'b1);
        #2;
        checkOutput("good.valid_cycles", n_valid - b_valid, 1);
        checkOutput("good.latency", valid_start - e0, 0);
        checkOutput("good.fields", {8'd0, cap_op, cap_a, cap_b}, 32'h00031234);
        checkOutput("good.errors", (n_chk - b_chk) + (n_to - b_to) + (n_ov - b_ov), 0);

        // Bad checksum: 01^0F^F0 = FE, sent 00.
        snap();
        send5(8'hAA, 8'h01, 8'h0F, 8'hF0, 8'h00, 1'b1);
        idle(3, 1'b1);
        #2;
        checkOutput("badchk.err_chk", n_chk - b_chk, 1);
        checkOutput("badchk.valid_cycles", n_valid - b_valid, 0);
        checkOutput("badchk.busy", {31'd0, busy}, 32'd0);

        // Leading garbage, then SYNC bytes used as payload.
        snap();
        applyStimulus(1'b1, 8'h55, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b1);
        send5(8'hAA, 8'hAA, 8'hAA, 8'h01, 8'h01, 1'b1);
        idle(3, 1'b1);
        #2;
        checkOutput("resync.valid_cycles", n_valid - b_valid, 1);
        checkOutput("resync.fields", {8'd0, cap_op, cap_a, cap_b}, 32'h00AAAA01);

        // Timeout after the opcode byte, then a full frame.
        snap();
        applyStimulus(1'b1, 8'hAA, 1'b1);
        applyStimulus(1'b1, 8'h07, 1'b1);
        e0 = cyc + 1;
        idle(T + 5, 1'b1);
        #2;
        checkOutput("timeout.count", n_to - b_to, 1);
        checkOutput("timeout.delay", to_cyc - e0, T);
        checkOutput("timeout.busy", {31'd0, busy}, 32'd0);
        snap();
        send5(8'hAA, 8'h07, 8'h01, 8'h02, 8'h04, 1'b1);
        idle(3, 1'b1);
        #2;
        checkOutput("after_to.fields", {8'd0, cap_op, cap_a, cap_b}, 32'h00070102);
        checkOutput("after_to.valid_cycles", n_valid - b_valid, 1);

        // Stall with overrun bytes, then a single transfer.
        snap();
        send5(8'hAA, 8'h03, 8'h12, 8'h34, 8'h25, 1'b0);
        idle(2, 1'b0);
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        idle(2, 1'b0);
        #2;
        checkOutput("stall.overruns", n_ov - b_ov, 2);
        checkOutput("stall.valid", {31'd0, cmd_valid}, 32'd1);
        checkOutput("stall.fields", {8'd0, cmd_op, cmd_a, cmd_b}, 32'h00031234);
        idle(3, 1'b1);
        idle(2, 1'b0);
        #2;
        checkOutput("stall.handshakes", n_hs - b_hs, 1);
        checkOutput("stall.idle_after", {30'd0, cmd_valid, busy}, 32'd0);

        // Reset in the middle of a frame.
        snap();
        applyStimulus(1'b1, 8'hAA, 1'b0);
        applyStimulus(1'b1, 8'h05, 1'b0);
        applyStimulus(1'b1, 8'h06, 1'b0);
        do_reset(2);
        #2;
        checkOutput("midrst.outputs", {1'b0, cmd_valid, busy, err_chk, err_timeout, err_overrun,
                                       2'b00, cmd_op, cmd_a, cmd_b}, 32'd0);
        idle(T + 3, 1'b1);
        #2;
        checkOutput("midrst.no_errors", (n_chk - b_chk) + (n_to - b_to) + (n_ov - b_ov), 0);
        snap();
        send5(8'hAA, 8'h01, 8'h02, 8'h03, 8'h00, 1'b1);
        idle(3, 1'b1);
        #2;
        checkOutput("midrst.next_frame", {8'd0, cap_op, cap_a, cap_b}, 32'h00010203);
        checkOutput("midrst.valid_cycles", n_valid - b_valid, 1);

        // Randomized frames: corrupt checksums, truncation, boundary gaps,
        // garbage, stalls and occasional resets.
        for (int f = 0; f < 250; f++) begin
            k     = $urandom_range(0, 9);
            fb[0] = 8'hAA;
            fb[1] = rnd_byte();
            fb[2] = rnd_byte();
            fb[3] = rnd_byte();
            fb[4] = fb[1] ^ fb[2] ^ fb[3];
            if (k == 1) fb[4] = fb[4] ^ 8'($urandom_range(1, 255));
            n = (k == 2) ? $urandom_range(2, 4) : 5;
            if (k == 0) applyStimulus(1'b1, rnd_byte(), rnd_ready());
            for (int i = 0; i < n; i++) begin
                applyStimulus(1'b1, fb[i], rnd_ready());
                if (k == 3 && i == 2) send_gap(T - 1 + $urandom_range(0, 1));
                else send_gap($urandom_range(0, 3));
            end
            if (k == 2) send_gap(T + 2);
            if (f % 97 == 50) do_reset(1);
        end
        idle(5, 1'b1);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
